// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock meter: FSM encodings and parameter defaults.
// Latency: none (declarations only).
// Backpressure: not applicable.
`timescale 1ns/1ps
package clock_meter_pkg;

  // Measurement FSM states, 3-bit encoded.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_LOST    = 3'd4
  } state_e;

  localparam int unsigned STABLE_N_DEF = 4;
  localparam int unsigned TIMEOUT_DEF  = 1000;

  // Match counter width; covers the allowed STABLE_N range of 2..15.
  localparam int unsigned MATCH_W = 4;

endpackage

// File: rtl/edge_sync.sv
// Synchronises an asynchronous level into clk and flags its rising/falling edges.
// Latency: an edge sampled by clk is flagged 2 cycles later and acted on at the 3rd edge.
// Backpressure: none; edges are single-cycle strobes that cannot be stalled.
`timescale 1ns/1ps
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic level
);

  logic       s1_q, s2_q, s3_q;
  logic [2:0] fill_q;
  logic       hist_ok;

  // Two-flop synchronizer, one history flop, and a fill tracker for the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fill_q <= 3'b000;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // Until s3 holds a real sample its reset 0 would make a high input look like a rise,
  // so edges are only reported once the history flop has been filled.
  assign hist_ok = fill_q[2];
  assign rise    = hist_ok &  s2_q & ~s3_q;
  assign fall    = hist_ok & ~s2_q &  s3_q;
  assign level   = s3_q;

endmodule

// File: rtl/clock_meter.sv
// Measures period and high time of an asynchronous square wave, reports lock and loss.
// Latency: outputs update 3 clk cycles after the sig_in edge that completes a measurement.
// Backpressure: none; period_valid is a one-cycle strobe with no ready handshake.
`timescale 1ns/1ps
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int STABLE_N = STABLE_N_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] STABLE_C  = MATCH_W'(STABLE_N);

  logic               rise, fall, level;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   period_q, high_time_q;
  logic [MATCH_W-1:0] match_q;
  state_e             state_q;
  logic               pv_q, locked_q, lost_q;
  logic               measuring;
  logic               timed_out;

  edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  // High time and period are only published while a measurement is in progress;
  // IDLE (no rise yet) and LOST keep the last published values.
  assign measuring = (state_q == ST_ACQUIRE) || (state_q == ST_MEASURE) ||
                     (state_q == ST_LOCKED);
  assign timed_out = !rise && (cnt_q >= TIMEOUT_C);

  // Next values of the saturating period and high-time counters.
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      cnt_d  = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (level && !fall && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_W'(1);
    end
  end

  // Counter registers and high-time capture on a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      hcnt_q      <= '0;
      high_time_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
      if (fall && measuring) high_time_q <= hcnt_q;
    end
  end

  // Measurement FSM with registered period, strobe, lock and loss outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      match_q  <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) state_q <= ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (rise) begin
            period_q <= cnt_q;
            pv_q     <= 1'b1;
            match_q  <= MATCH_W'(1);
            state_q  <= ST_MEASURE;
          end else if (timed_out) begin
            state_q <= ST_LOST;
            lost_q  <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period_q <= cnt_q;
            pv_q     <= 1'b1;
            if (cnt_q == period_q) begin
              match_q <= match_q + MATCH_W'(1);
              if ((match_q + MATCH_W'(1)) >= STABLE_C) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              match_q <= MATCH_W'(1);
            end
          end else if (timed_out) begin
            state_q <= ST_LOST;
            lost_q  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (rise) begin
            period_q <= cnt_q;
            pv_q     <= 1'b1;
            if (cnt_q != period_q) begin
              match_q  <= MATCH_W'(1);
              state_q  <= ST_MEASURE;
              locked_q <= 1'b0;
            end
          end else if (timed_out) begin
            state_q  <= ST_LOST;
            locked_q <= 1'b0;
            lost_q   <= 1'b1;
          end
        end
        ST_LOST: begin
          if (rise) begin
            state_q <= ST_ACQUIRE;
            lost_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
          lost_q   <= 1'b0;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_clock_meter.sv
// Directed bench for clock_meter: reset, lock, drift, loss, timeout boundary, async reset.
// Latency: checks sample on the falling clk edge, well after outputs settle.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_clock_meter;

  logic        clk;
  logic        rst_n;
  logic        sig_in;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        period_valid;
  logic        locked;
  logic        lost;

  int vectors     = 0;
  int miscompares = 0;

  int cyc       = 0;
  int pv_count  = 0;
  int pv_last   = 0;
  int pv_gap    = 0;
  bit lost_seen = 1'b0;

  clock_meter #(.CNT_W(16), .STABLE_N(4), .TIMEOUT(1000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Event monitor: counts strobes, measures strobe spacing, remembers any loss.
  always @(posedge clk) begin
    #0.5;
    cyc = cyc + 1;
    if (period_valid) begin
      pv_count = pv_count + 1;
      pv_gap   = cyc - pv_last;
      pv_last  = cyc;
    end
    if (lost) lost_seen = 1'b1;
  end

  task automatic clear_mon();
    pv_count  = 0;
    pv_gap    = 0;
    lost_seen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();
  endtask

  task automatic drive_period(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(negedge clk);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (period !== 16'd0) begin miscompares++; $display("FAIL rst_period: got %0d want 0", period); end
    vectors++; if (high_time !== 16'd0) begin miscompares++; $display("FAIL rst_high_time: got %0d want 0", high_time); end
    vectors++; if (period_valid !== 1'b0) begin miscompares++; $display("FAIL rst_pv: got %b want 0", period_valid); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_locked: got %b want 0", locked); end
    vectors++; if (lost !== 1'b0) begin miscompares++; $display("FAIL rst_lost: got %b want 0", lost); end
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  // sig_in already high through reset; it must never count as a rise.
  task automatic test_const_high();
    repeat (5000) @(negedge clk);
    vectors++; if (pv_count !== 0) begin miscompares++; $display("FAIL const_high_pv: got %0d pulses want 0", pv_count); end
    vectors++; if (lost_seen !== 1'b0) begin miscompares++; $display("FAIL const_high_lost: got %b want 0", lost_seen); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL const_high_locked: got %b want 0", locked); end
    // First fall with no preceding rise is ignored.
    sig_in = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (high_time !== 16'd0) begin miscompares++; $display("FAIL fall_first_high_time: got %0d want 0", high_time); end
    vectors++; if (period !== 16'd0) begin miscompares++; $display("FAIL fall_first_period: got %0d want 0", period); end
  endtask

  task automatic test_lock12();
    do_reset();
    repeat (4) drive_period(6, 6);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL lock12_early: got %b want 0", locked); end
    vectors++; if (pv_count !== 3) begin miscompares++; $display("FAIL lock12_pv3: got %0d want 3", pv_count); end
    drive_period(6, 6);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock12_locked: got %b want 1", locked); end
    vectors++; if (period !== 16'd12) begin miscompares++; $display("FAIL lock12_period: got %0d want 12", period); end
    vectors++; if (high_time !== 16'd6) begin miscompares++; $display("FAIL lock12_high: got %0d want 6", high_time); end
    vectors++; if (pv_count !== 4) begin miscompares++; $display("FAIL lock12_pv4: got %0d want 4", pv_count); end
    vectors++; if (pv_gap !== 12) begin miscompares++; $display("FAIL lock12_gap: got %0d want 12", pv_gap); end
  endtask

  task automatic test_stretch();
    drive_period(6, 8);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL stretch_still_locked: got %b want 1", locked); end
    drive_period(6, 6);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL stretch_unlock: got %b want 0", locked); end
    vectors++; if (period !== 16'd14) begin miscompares++; $display("FAIL stretch_period: got %0d want 14", period); end
    repeat (3) drive_period(6, 6);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL stretch_relock_early: got %b want 0", locked); end
    drive_period(6, 6);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL stretch_relock: got %b want 1", locked); end
    vectors++; if (period !== 16'd12) begin miscompares++; $display("FAIL stretch_period12: got %0d want 12", period); end
  endtask

  task automatic test_lost();
    clear_mon();
    repeat (900) @(negedge clk);
    vectors++; if (lost !== 1'b0) begin miscompares++; $display("FAIL lost_early: got %b want 0", lost); end
    repeat (200) @(negedge clk);
    vectors++; if (lost !== 1'b1) begin miscompares++; $display("FAIL lost_set: got %b want 1", lost); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL lost_locked: got %b want 0", locked); end
    vectors++; if (period !== 16'd12) begin miscompares++; $display("FAIL lost_period_hold: got %0d want 12", period); end
    vectors++; if (high_time !== 16'd6) begin miscompares++; $display("FAIL lost_high_hold: got %0d want 6", high_time); end
    clear_mon();
    drive_period(6, 6);
    vectors++; if (lost !== 1'b0) begin miscompares++; $display("FAIL lost_clear: got %b want 0", lost); end
    vectors++; if (pv_count !== 0) begin miscompares++; $display("FAIL lost_first_rise_pv: got %0d want 0", pv_count); end
    drive_period(6, 6);
    vectors++; if (pv_count !== 1) begin miscompares++; $display("FAIL lost_second_rise_pv: got %0d want 1", pv_count); end
    vectors++; if (period !== 16'd12) begin miscompares++; $display("FAIL lost_resume_period: got %0d want 12", period); end
  endtask

  task automatic test_reset_mid();
    repeat (4) drive_period(6, 6);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL rmid_prelock: got %b want 1", locked); end
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #0.2;
    vectors++; if (period !== 16'd0) begin miscompares++; $display("FAIL rmid_period: got %0d want 0", period); end
    vectors++; if (high_time !== 16'd0) begin miscompares++; $display("FAIL rmid_high: got %0d want 0", high_time); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rmid_locked: got %b want 0", locked); end
    vectors++; if (lost !== 1'b0 || period_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_flags: got lost=%b pv=%b want 0/0", lost, period_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (2) @(negedge clk);
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    drive_period(6, 6);
    vectors++; if (pv_count !== 0) begin miscompares++; $display("FAIL rmid_first_rise_pv: got %0d want 0", pv_count); end
    drive_period(6, 6);
    vectors++; if (pv_count !== 1) begin miscompares++; $display("FAIL rmid_second_rise_pv: got %0d want 1", pv_count); end
    vectors++; if (period !== 16'd12) begin miscompares++; $display("FAIL rmid_period12: got %0d want 12", period); end
  endtask

  // Rises exactly TIMEOUT cycles apart win over the timeout; one cycle more is a loss.
  task automatic test_timeout_boundary();
    do_reset();
    repeat (3) drive_period(6, 994);
    vectors++; if (lost_seen !== 1'b0) begin miscompares++; $display("FAIL tmo_edge_lost: got %b want 0", lost_seen); end
    vectors++; if (period !== 16'd1000) begin miscompares++; $display("FAIL tmo_edge_period: got %0d want 1000", period); end
    vectors++; if (pv_count !== 2) begin miscompares++; $display("FAIL tmo_edge_pv: got %0d want 2", pv_count); end
    drive_period(6, 995);
    repeat (5) @(negedge clk);
    vectors++; if (lost !== 1'b1) begin miscompares++; $display("FAIL tmo_over_lost: got %b want 1", lost); end
    vectors++; if (period !== 16'd1000) begin miscompares++; $display("FAIL tmo_over_period: got %0d want 1000", period); end
    vectors++; if (pv_count !== 3) begin miscompares++; $display("FAIL tmo_over_pv: got %0d want 3", pv_count); end
  endtask

  // sig_in toggles every 3 time units against a 2-unit clk: 3-cycle period.
  task automatic test_fast();
    do_reset();
    #0.5;
    for (int i = 0; i < 60; i++) begin
      sig_in = ~sig_in;
      #3;
    end
    @(negedge clk);
    vectors++; if (period !== 16'd3) begin miscompares++; $display("FAIL fast_period: got %0d want 3", period); end
    vectors++; if (!(high_time == 16'd1 || high_time == 16'd2)) begin miscompares++; $display("FAIL fast_high: got %0d want 1 or 2", high_time); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL fast_locked: got %b want 1", locked); end
    vectors++; if (pv_gap !== 3) begin miscompares++; $display("FAIL fast_gap: got %0d want 3", pv_gap); end
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    test_reset();
    test_const_high();
    test_lock12();
    test_stretch();
    test_lost();
    test_reset_mid();
    test_timeout_boundary();
    test_fast();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
